// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART transmitter and receiver.
// The PARITY state is only reached when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period; restart forces the count back to zero.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  input  logic i_en,
  output logic o_bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last     = (r_cnt == LAST);
  assign o_bit_done = i_en && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || !i_en) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_rtl.sv
// 8N1 (or 8N2) UART transmitter, LSB first, registered txd.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx_rtl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy
);

  localparam int   CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  // Any STOP_BITS value above 1 is treated as two stop bits.
  localparam logic STOP_LAST    = (STOP_BITS >= 2);

  uart_state_e          r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_nxt;
  logic [2:0]           r_bit_idx, w_bit_idx_nxt;
  logic                 r_stop_cnt, w_stop_cnt_nxt;
  logic                 r_txd, w_txd_nxt;
  logic                 w_accept;
  logic                 w_bit_done;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity, w_parity_nxt;
`endif

  assign tx_ready = (r_state == IDLE);
  assign tx_busy  = ~tx_ready;
  assign txd      = r_txd;
  assign w_accept = tx_valid && tx_ready;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_accept),
    .i_en      (r_state != IDLE),
    .o_bit_done(w_bit_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_txd      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_txd      <= w_txd_nxt;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity_nxt;
`endif
    end
  end

  // txd is computed one cycle ahead so the line changes exactly on state edges.
  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_cnt_nxt = r_stop_cnt;
    w_txd_nxt      = r_txd;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt   = r_parity;
`endif
    case (r_state)
      IDLE: begin
        w_txd_nxt = 1'b1;
        if (tx_valid) begin
          w_state_nxt   = START;
          w_shreg_nxt   = tx_data;
          w_bit_idx_nxt = '0;
          w_txd_nxt     = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_parity_nxt  = ^tx_data;
`endif
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_nxt   = DATA;
          w_txd_nxt     = r_shreg[0];
          w_shreg_nxt   = {1'b0, r_shreg[DATA_BITS-1:1]};
          w_bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt    = PARITY;
            w_txd_nxt      = r_parity;
`else
            w_state_nxt    = STOP;
            w_txd_nxt      = 1'b1;
            w_stop_cnt_nxt = 1'b0;
`endif
          end else begin
            w_txd_nxt     = r_shreg[0];
            w_shreg_nxt   = {1'b0, r_shreg[DATA_BITS-1:1]};
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_done) begin
          w_state_nxt    = STOP;
          w_txd_nxt      = 1'b1;
          w_stop_cnt_nxt = 1'b0;
        end
      end
`endif
      STOP: begin
        w_txd_nxt = 1'b1;
        if (w_bit_done) begin
          if (r_stop_cnt == STOP_LAST) begin
            w_state_nxt = IDLE;
          end else begin
            w_stop_cnt_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_rtl.sv
// Directed bench for uart_tx_rtl: one instance at 16 clocks/bit with one stop
// bit, a second at 105k/10k (10 clocks/bit) with two stop bits.
module tb_uart_tx_rtl;

  localparam int CPB1 = 16;
  localparam int CPB2 = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00, tx_data2 = 8'h00;
  logic       tx_valid = 1'b0, tx_valid2 = 1'b0;
  logic       tx_ready, txd, tx_busy;
  logic       tx_ready2, txd2, tx_busy2;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_rtl #(.CLK_FREQ(160_000), .BAUD_RATE(10_000), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy));

  uart_tx_rtl #(.CLK_FREQ(105_000), .BAUD_RATE(10_000), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .txd(txd2), .tx_busy(tx_busy2));

  // Called at a negedge with the selected DUT idle; returns just after the accept edge.
  task automatic send(input bit sel, input logic [7:0] d);
    if (sel) begin tx_data2 = d; tx_valid2 = 1'b1; end
    else     begin tx_data  = d; tx_valid  = 1'b1; end
    @(posedge clk);
  endtask

  // Follows a frame from the accept edge to the first idle negedge.
  task automatic frame_check(input bit sel, input logic [7:0] d, input int cpb,
                             input int nstop, input bit keep_valid,
                             input logic [7:0] next_data, input string tag);
    logic exp_bits[$];
    int   bad;
    int   busy_cnt;
    logic bad_val;
    logic t_s, r_s, b_s;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (PB == 1) exp_bits.push_back(^d);
    for (int s = 0; s < nstop; s++) exp_bits.push_back(1'b1);
    busy_cnt = 0;
    for (int b = 0; b < exp_bits.size(); b++) begin
      bad = 0;
      bad_val = 1'b0;
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (b == 0 && c == 0) begin
          if (sel) begin tx_valid2 = keep_valid; tx_data2 = next_data; end
          else     begin tx_valid  = keep_valid; tx_data  = next_data; end
        end
        t_s = sel ? txd2 : txd;
        r_s = sel ? tx_ready2 : tx_ready;
        b_s = sel ? tx_busy2 : tx_busy;
        if (b_s === 1'b1) busy_cnt++;
        if (t_s !== exp_bits[b] || r_s !== 1'b0) begin
          if (bad == 0) bad_val = t_s;
          bad++;
        end
      end
      n_assert++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s bit%0d: txd=%b (%0d bad cycles, ready must be 0), required txd=%b",
                 tag, b, bad_val, bad, exp_bits[b]);
      end
    end
    n_assert++;
    if (busy_cnt != exp_bits.size() * cpb) begin
      n_fail++;
      $display("FAIL %s frame_len: busy %0d clocks, required %0d", tag, busy_cnt,
               exp_bits.size() * cpb);
    end
    @(negedge clk);
    t_s = sel ? txd2 : txd;
    r_s = sel ? tx_ready2 : tx_ready;
    b_s = sel ? tx_busy2 : tx_busy;
    n_assert++;
    if ({t_s, r_s, b_s} !== 3'b110) begin
      n_fail++;
      $display("FAIL %s idle_after: txd/ready/busy=%b%b%b, required 110", tag, t_s, r_s, b_s);
    end
  endtask

  task automatic test_reset;
    int bad;
    @(negedge clk);
    n_assert++;
    if ({txd, tx_ready, tx_busy, txd2, tx_ready2, tx_busy2} !== 6'b110110) begin
      n_fail++;
      $display("FAIL reset_vals: got %b%b%b %b%b%b, required 110 110",
               txd, tx_ready, tx_busy, txd2, tx_ready2, tx_busy2);
    end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ({txd, tx_ready, tx_busy, txd2, tx_ready2, tx_busy2} !== 6'b110110) bad++;
    end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_idle: %0d non-idle cycles, required 0", bad);
    end
  endtask

  task automatic test_single;
    send(1'b0, 8'hD8);
    frame_check(1'b0, 8'hD8, CPB1, 1, 1'b0, 8'h00, "single_d8");
  endtask

  task automatic test_patterns;
    logic [7:0] vec [4];
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h01; vec[3] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, vec[i]);
      frame_check(1'b0, vec[i], CPB1, 1, 1'b0, 8'h00, $sformatf("pat_%02h", vec[i]));
    end
  endtask

  task automatic test_back_to_back;
    int t0, t1;
    send(1'b0, 8'h9C);
    #1 t0 = cyc;
    frame_check(1'b0, 8'h9C, CPB1, 1, 1'b1, 8'hB4, "b2b_9c");
    @(posedge clk);
    #1 t1 = cyc;
    n_assert++;
    if (t1 - t0 != (10 + PB) * CPB1 + 1) begin
      n_fail++;
      $display("FAIL b2b_spacing: %0d clocks, required %0d", t1 - t0, (10 + PB) * CPB1 + 1);
    end
    frame_check(1'b0, 8'hB4, CPB1, 1, 1'b0, 8'h00, "b2b_b4");
  endtask

  task automatic test_reset_mid;
    send(1'b0, 8'h55);
    for (int i = 0; i < 4 * CPB1 + CPB1 / 2; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    n_assert++;
    if (txd !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_bit3: txd=%b, required 0", txd);
    end
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({txd, tx_ready, tx_busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_reset: txd/ready/busy=%b%b%b, required 110", txd, tx_ready, tx_busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({txd, tx_ready, tx_busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_release: txd/ready/busy=%b%b%b, required 110", txd, tx_ready, tx_busy);
    end
    send(1'b0, 8'hA5);
    frame_check(1'b0, 8'hA5, CPB1, 1, 1'b0, 8'h00, "after_rst_a5");
  endtask

  task automatic test_stop2;
    send(1'b1, 8'hD8);
    frame_check(1'b1, 8'hD8, CPB2, 2, 1'b0, 8'h00, "stop2_d8");
    send(1'b1, 8'h3C);
    frame_check(1'b1, 8'h3C, CPB2, 2, 1'b0, 8'h00, "stop2_3c");
  endtask

  task automatic test_parity;
    send(1'b0, 8'h07);
    frame_check(1'b0, 8'h07, CPB1, 1, 1'b0, 8'h00, "par_07");
    send(1'b0, 8'hD8);
    frame_check(1'b0, 8'hD8, CPB1, 1, 1'b0, 8'h00, "par_d8");
  endtask

  initial begin
    test_reset;
    test_single;
    test_patterns;
    test_back_to_back;
    test_reset_mid;
    test_stop2;
    test_parity;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
